// File: rtl/rr_priority_encoder_pkg.sv
// Shared constants and the index-to-onehot helper used by the encoder and the decoder path.
package rr_priority_encoder_pkg;

  localparam int N = 16;
  localparam int W = 4;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/acknowledge and index valid/ready bundle between requesters, encoder and consumer.
interface rr_priority_encoder_if;

  logic [rr_priority_encoder_pkg::N-1:0] req;
  logic [rr_priority_encoder_pkg::N-1:0] ack;
  logic                                  out_valid;
  logic [rr_priority_encoder_pkg::W-1:0] out_index;
  logic                                  out_ready;
  logic                                  busy;

  modport master (
    input  req,
    input  out_ready,
    output ack,
    output out_valid,
    output out_index,
    output busy
  );

  modport slave (
    output req,
    output out_ready,
    input  ack,
    input  out_valid,
    input  out_index,
    input  busy
  );

endinterface

// File: rtl/rr_priority_encoder_rr_pick.sv
// Combinational rotating find-first-one: picks the first set bit of cand at or after ptr.
// Zero latency; no flow control of its own.
module rr_priority_encoder_rr_pick
  import rr_priority_encoder_pkg::*;
(
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         found
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;

  // rot[k] == cand[(ptr + k) mod N], so the lowest set bit of rot is the winner.
  always_comb begin
    dbl = {cand, cand} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = W'(k);
      end
    end
    found = |cand;
    sel   = ptr + off;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered 16-to-4 round-robin encoder with one-hot ack on the output handshake.
// One cycle request-to-index latency; a stalled output freezes index, valid and pointer.
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  rr_priority_encoder_if.master bus
);

  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic         found;
  logic         load;
  logic [N-1:0] mask;
  logic [N-1:0] cand;

  assign load = !bus.out_valid || bus.out_ready;

  // Masking the held index even while it is being accepted stops a requester whose
  // req has not dropped yet from winning again on the very next edge.
  assign mask = bus.out_valid ? onehot(bus.out_index) : '0;
  assign cand = bus.req & ~mask;

  assign bus.ack  = (bus.out_valid && bus.out_ready) ? onehot(bus.out_index) : '0;
  assign bus.busy = bus.out_valid || (bus.req != '0);

  rr_priority_encoder_rr_pick u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .sel   (sel),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_index <= '0;
      ptr           <= '0;
    end else if (load) begin
      if (found) begin
        bus.out_valid <= 1'b1;
        bus.out_index <= sel;
        ptr           <= sel + W'(1);
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench: stimulus pushes expected grant indices, a negedge monitor pops them on each handshake.
module tb_rr_priority_encoder;
  import rr_priority_encoder_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rr_priority_encoder_if bus ();

  rr_priority_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // Scoreboard side: every accepted index must match the oldest expected grant.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got index %0d want no grant", bus.out_index);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("grant_index", 32'(bus.out_index), 32'(e));
          check("grant_ack", 32'(bus.ack), 32'(onehot(e)));
        end
      end else begin
        check("ack_idle", 32'(bus.ack), 32'h0);
      end
    end
  end

  initial begin
    bus.req       = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    step(2);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_index", 32'(bus.out_index), 32'h0);
    check("rst_ack",   32'(bus.ack),       32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    mon_en = 1'b1;
    reset  = 1'b0;

    // 1: single request, one-cycle latency, masked while req lingers through ack
    bus.req = 16'h0001;
    exp_q.push_back(4'd0);
    step(1);
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    step(1);
    bus.req = '0;
    check("t1_idle", 32'(bus.out_valid), 32'h0);

    // 2: two sticky requesters alternate 0,15,...
    do_reset();
    bus.req = 16'h8001;
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 4'd0 : 4'd15);
    step(6);
    bus.req = '0;
    step(1);
    check("t2_idle", 32'(bus.out_valid), 32'h0);

    // 3: backpressure holds index 4 stable with no ack
    bus.req       = 16'h0010;
    bus.out_ready = 1'b0;
    exp_q.push_back(4'd4);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(bus.out_valid), 32'h1);
      check("t3_hold_index", 32'(bus.out_index), 32'h4);
      check("t3_busy",       32'(bus.busy),      32'h1);
      step(1);
    end
    bus.out_ready = 1'b1;
    step(1);
    bus.req = '0;
    check("t3_after_ack", 32'(bus.out_valid), 32'h0);

    // 4: all requesters, full rotation with wrap 15 -> 0
    do_reset();
    bus.req = 16'hFFFF;
    for (int i = 0; i < 18; i++) exp_q.push_back(4'(i % 16));
    step(18);
    bus.req = '0;
    step(1);
    check("t4_idle", 32'(bus.out_valid), 32'h0);

    // 5: retraction while held still delivers index 3
    bus.req       = 16'h0008;
    bus.out_ready = 1'b0;
    exp_q.push_back(4'd3);
    step(1);
    check("t5_valid", 32'(bus.out_valid), 32'h1);
    check("t5_index", 32'(bus.out_index), 32'h3);
    bus.req = '0;
    step(1);
    check("t5_retained_valid", 32'(bus.out_valid), 32'h1);
    check("t5_retained_index", 32'(bus.out_index), 32'h3);
    bus.out_ready = 1'b1;
    step(1);
    check("t5_valid_after", 32'(bus.out_valid), 32'h0);
    check("t5_busy_after",  32'(bus.busy),      32'h0);

    // 6: reset discards held index 7, search restarts at 0
    bus.req       = 16'h0080;
    bus.out_ready = 1'b0;
    step(1);
    check("t6_held_valid", 32'(bus.out_valid), 32'h1);
    check("t6_held_index", 32'(bus.out_index), 32'h7);
    reset = 1'b1;
    step(1);
    check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    check("t6_rst_index", 32'(bus.out_index), 32'h0);
    check("t6_rst_ack",   32'(bus.ack),       32'h0);
    reset         = 1'b0;
    bus.req       = 16'h0081;
    bus.out_ready = 1'b1;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd7);
    step(2);
    bus.req = 16'h0080;
    step(1);
    bus.req = '0;
    check("t6_idle", 32'(bus.out_valid), 32'h0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
